active_list: RTL

//  In-order rename record buffer: the consumer of register_Map_Table_Pairing_ifc.
//  - Rename pushes one record per instruction: prev mapping of rw plus the new physical reg.
//  - Writeback marks records done.
//  - Head retires in order and returns prev_physical_reg to the free list.
//  - On flush, a rollback FSM pops squashed records youngest-first. Each pop restores
//    the map table and returns the squashed new physical reg.

---
 rtl/active_list.sv | 130 +++++++++++++
 1 files changed

// File: rtl/active_list.sv
// In-order rename record buffer: allocates records at rename, retires them in order,
// and on a flush rolls back squashed records youngest-first to repair the map table.
module active_list #(
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned PHYS_REGS = 64,
   parameter int unsigned LOG_REGS  = 32,
   localparam int TAG_W = $clog2(DEPTH),
   localparam int PR_W  = $clog2(PHYS_REGS),
   localparam int LR_W  = $clog2(LOG_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic             alloc_uses_rw,
   input  logic [PR_W-1:0]  alloc_prev_phys,
   input  logic [LR_W-1:0]  alloc_prev_log,
   input  logic [PR_W-1:0]  alloc_new_phys,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             wb_valid,
   input  logic [TAG_W-1:0] wb_tag,
   input  logic             flush_valid,
   input  logic [TAG_W-1:0] flush_tag,
   output logic             commit_valid,
   output logic [TAG_W-1:0] commit_tag,
   output logic             free_valid,
   output logic [PR_W-1:0]  free_phys,
   output logic             restore_valid,
   output logic [LR_W-1:0]  restore_log,
   output logic [PR_W-1:0]  restore_phys,
   output logic             busy
);

   typedef enum logic {RUN, ROLLBACK} state_t;

   state_t           state, state_next;
   logic [TAG_W-1:0] head, tail, stop, tail_m1, tail_m2;
   logic [TAG_W:0]   count;
   logic [DEPTH-1:0] valid, done, uses_rw;
   logic [PR_W-1:0]  prev_phys [DEPTH];
   logic [PR_W-1:0]  new_phys  [DEPTH];
   logic [LR_W-1:0]  prev_log  [DEPTH];
   logic             do_alloc, do_pop, flush_hit;

   always_comb begin
      tail_m1       = tail - TAG_W'(1);
      tail_m2       = tail - TAG_W'(2);
      alloc_ready   = (state == RUN) && (count < (TAG_W+1)'(DEPTH));
      do_alloc      = alloc_valid && alloc_ready;
      do_pop        = (state == ROLLBACK);
      commit_valid  = (state == RUN) && (count != '0) && done[head];
      flush_hit     = (state == RUN) && flush_valid && valid[flush_tag] && (flush_tag != tail_m1);
      alloc_tag     = tail;
      commit_tag    = head;
      busy          = do_pop;
      free_valid    = 1'b0;
      free_phys     = '0;
      restore_valid = 1'b0;
      restore_log   = '0;
      restore_phys  = '0;
      // Retire frees the old mapping; rollback frees the squashed new mapping instead.
      if (commit_valid) begin
         free_valid = uses_rw[head];
         if (uses_rw[head]) free_phys = prev_phys[head];
      end else if (do_pop) begin
         free_valid    = uses_rw[tail_m1];
         restore_valid = uses_rw[tail_m1];
         if (uses_rw[tail_m1]) begin
            free_phys    = new_phys[tail_m1];
            restore_log  = prev_log[tail_m1];
            restore_phys = prev_phys[tail_m1];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:      if (flush_hit) state_next = ROLLBACK;
         ROLLBACK: if (tail_m2 == stop) state_next = RUN;
         default:  state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         head  <= '0;
         tail  <= '0;
         stop  <= '0;
         count <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         state <= state_next;
         if (flush_hit) stop <= flush_tag;
         // Later clears override a same-cycle writeback to a slot being removed.
         if (wb_valid && valid[wb_tag]) done[wb_tag] <= 1'b1;
         if (do_alloc) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
         end
         if (commit_valid) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
            head        <= head + TAG_W'(1);
         end
         if (do_pop) begin
            valid[tail_m1] <= 1'b0;
            done[tail_m1]  <= 1'b0;
            tail           <= tail_m1;
            count          <= count - (TAG_W+1)'(1);
         end else begin
            if (do_alloc) tail <= tail + TAG_W'(1);
            if (do_alloc && !commit_valid) count <= count + (TAG_W+1)'(1);
            else if (!do_alloc && commit_valid) count <= count - (TAG_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_alloc) begin
         uses_rw[tail]   <= alloc_uses_rw;
         prev_phys[tail] <= alloc_prev_phys;
         prev_log[tail]  <= alloc_prev_log;
         new_phys[tail]  <= alloc_new_phys;
      end
   end

endmodule
